// File: rtl/button_cond_pkg.sv
// Shared types and constants for the calculator button conditioner.
package button_cond_pkg;

    // Per-channel debounce state
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 10 ms debounce and 1 s long press at 50 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_LONG_CYCLES     = 50000000;

    // Bit positions inside the button vectors
    localparam int BTN_SUM   = 0;
    localparam int BTN_SUB   = 1;
    localparam int BTN_MULT  = 2;
    localparam int BTN_ONOFF = 3;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-FF synchroniser, arming, debounce FSM with a
// saturating stable-sample counter, registered level and pulse outputs.
// Long-press detection is built only when BUTTON_CONDITIONER_LONG_PRESS_EN
// is defined; otherwise long_pulse is constant 0.
module button_debounce_ch
    import button_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic level_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif
    localparam int CNT_MAX = max_i(DEBOUNCE_CYCLES, LONG_EN ? LONG_CYCLES : 0);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_FULL = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1, sync2;
    logic [1:0]       vld_pipe;
    logic             armed;
    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, press_nxt, rel_nxt, long_nxt;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LG_FULL = CNT_W'(LONG_CYCLES);
    logic long_done, long_done_nxt;
`endif

    // Synchroniser; vld_pipe marks when sync2 holds a real pad sample rather
    // than its reset value, so a button held through reset never arms
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            vld_pipe <= 2'b00;
            armed    <= 1'b0;
        end else begin
            sync1    <= raw_n;
            sync2    <= sync1;
            vld_pipe <= {vld_pipe[0], 1'b1};
            armed    <= armed | (vld_pipe[1] & sync2);
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            level_n       <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
            long_done     <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            level_n       <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= rel_nxt;
            long_pulse    <= long_nxt;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
            long_done     <= long_done_nxt;
`endif
        end
    end

    // Next-state logic; any bounce restarts the count in the wait states
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level_n;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        long_nxt  = 1'b0;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
        long_done_nxt = long_done;
`endif
        case (state)
            IDLE: begin
                if (armed && !sync2) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (sync2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = DB_FULL;
                    press_nxt = 1'b1;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (sync2) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
                // long_done survives release bounces so the pulse fires once per press
                else if (!long_done) begin
                    if (cnt >= LG_LAST) begin
                        cnt_nxt       = LG_FULL;
                        long_nxt      = 1'b1;
                        long_done_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
`endif
            end
            RELEASE_WAIT: begin
                if (!sync2) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    rel_nxt   = 1'b1;
                    level_nxt = 1'b1;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
                    long_done_nxt = 1'b0;
`endif
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// Calculator push-button conditioner: N_BTN independent debounce channels,
// bit order {on/off, mult, sub, sum}. Optional long-press detection is
// enabled by defining BUTTON_CONDITIONER_LONG_PRESS_EN.
module button_conditioner
    import button_cond_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw_n,
    output logic [N_BTN-1:0] btn_level_n,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .raw_n         (btn_raw_n[i]),
            .level_n       (btn_level_n[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .long_pulse    (btn_long[i])
        );
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the four raw, active-low calculator push-buttons (sum, subtract, multiply, on/off) before they reach the calculator state machine. Each button is synchronised to `clk`, debounced with a stable-sample counter, and converted into a clean active-low level plus single-cycle press and release pulses. The calculator stage then acts on exactly one event per physical press, regardless of contact bounce.

## Interface
- `N_BTN`, 4: number of button channels; bit order is {on/off, mult, sub, sum}.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable samples required to accept a level change (10 ms at 50 MHz); must be ≥ 2.
- `LONG_CYCLES`, 50000000: held-cycles threshold for a long press; used only when the long-press feature is compiled in.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_raw_n`  in  N_BTN  raw pad levels, 0 = pressed, asynchronous to `clk`.
- `btn_level_n`  out  N_BTN  debounced level, 0 = pressed.
- `btn_press`  out  N_BTN  one-cycle pulse on an accepted press.
- `btn_release`  out  N_BTN  one-cycle pulse on an accepted release.
- `btn_long`  out  N_BTN  one-cycle pulse once per press held ≥ `LONG_CYCLES`.

## Operation
- **Channels:** all channels are independent and identical. Several channels may pulse in the same cycle; there is no priority between them.
- **Synchroniser:** a 2-FF synchroniser per bit, with both flops resetting to 1 (released).
- **Per-channel FSM**
  - IDLE: the synchronised input is 0 → go to PRESS_WAIT with count = 1.
  - PRESS_WAIT
    - Input returns to 1 → go to IDLE with count = 0. Bounces fully restart the count.
    - Count reaches `DEBOUNCE_CYCLES` → go to PRESSED, drive `btn_level_n` = 0, pulse `btn_press`.
  - PRESSED: input is 1 → go to RELEASE_WAIT with count = 1.
  - RELEASE_WAIT
    - Input returns to 0 → go back to PRESSED with count = 0.
    - Count reaches `DEBOUNCE_CYCLES` → go to IDLE, drive `btn_level_n` = 1, pulse `btn_release`.
- **Arming:** each channel has an `armed` flag, cleared by reset and set the first time the synchronised input is seen as 1.
  - While the flag is clear, the FSM stays in IDLE.
  - Consequence: a button held through reset produces no press until it has been released once.
- **Counter width:** `CNT_W = $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES) + 1)`. The counter saturates and never wraps.
- **Long press:** the count continues in PRESSED. `btn_long` pulses exactly once when the count hits `LONG_CYCLES`, then the count holds. It does not re-pulse until the next release/press cycle.

## Timing
- **Reset values:** `btn_level_n` = all ones; `btn_press`, `btn_release` and `btn_long` = 0; FSM = IDLE; counters = 0; `armed` = 0; synchronisers = 1.
- **Press latency:** suppose the raw input is low from the edge that samples it at cycle k, is stable, and the channel is armed. Then `btn_press` is high for exactly the one cycle after edge k + 1 + `DEBOUNCE_CYCLES`, i.e. a latency of `DEBOUNCE_CYCLES` + 2. `btn_level_n` falls in that same cycle.
- **Release latency:** symmetric to press latency, with `btn_release`.
- **Pulse width:** exactly one cycle, registered (no combinational path from input to output).
- **Bounce:** a glitch shorter than `DEBOUNCE_CYCLES` cycles produces no output change.
- **Reset mid-operation:** asserting `rst_n` drops all outputs to their reset values on the same edge. No release pulse is generated for a button that was pressed when reset hit.
- **Consumer convention:** downstream logic treats `btn_level_n` as an active-low button and `btn_press` as its edge event.

## Configuration
- **`BUTTON_CONDITIONER_LONG_PRESS_EN`**
  - Defined: the long-press counter and `btn_long` logic are built as described above.
  - Undefined: `btn_long` is tied to 0, `LONG_CYCLES` is ignored, and `CNT_W` sizes from `DEBOUNCE_CYCLES` only.

## Structure
- **Package `button_cond_pkg`:**
  - the channel state typedef {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT};
  - default constants for `DEBOUNCE_CYCLES` and `LONG_CYCLES`;
  - named bit indices BTN_SUM = 0, BTN_SUB = 1, BTN_MULT = 2, BTN_ONOFF = 3.
- **Sub-module `button_debounce_ch`:** one channel (synchroniser, FSM, counter, arming), instantiated `N_BTN` times in a generate loop. The top level does wiring only.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `LONG_CYCLES` = 20.
- **Clean press:** release all buttons after reset for 10 cycles, then drive bit 0 low and hold → `btn_press[0]` pulses at exactly cycle 6 after the low sample; `btn_level_n[0]` = 0 from then on.
- **Bounce rejection:** toggle bit 1 low/high every 2 cycles for 20 cycles → no `btn_press[1]`, and `btn_level_n[1]` stays 1.
- **Release:** release held bit 0 after a stable press → `btn_release[0]` pulses 6 cycles later; `btn_level_n[0]` returns to 1.
- **Held through reset:** hold bit 3 low through and after reset deassertion for 50 cycles → no `btn_press[3]`; release, then press again → a normal press pulse.
- **Simultaneous press:** press bits 0 and 2 on the same cycle → both `btn_press` bits pulse in the same cycle.
- **Long press (macro defined):** hold bit 2 for 40 cycles → exactly one `btn_long[2]` pulse, 20 counts after the press; with the macro undefined, `btn_long` stays 0.
